rect_fill_engine: RTL and testbench

//  GPU-side pixel producer: accepts rectangle-fill commands and writes them pixel by pixel

---
 rtl/gpu_pkg.sv | 29 ++
 rtl/raster_scan_counter.sv | 49 ++++
 rtl/rect_fill_engine.sv | 112 +++++++++++
 tb/tb_rect_fill_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU pixel-path types: coordinate/pixel widths, fill FSM states, latched command layout.
// Also holds the default visible screen size and corner-normalisation helpers.
package gpu_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] pixel_t;

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
    pixel_t color;
  } fill_cmd_t;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/raster_scan_counter.sv
// Row-major x/y stepper over a loaded inclusive rectangle; x/y are the current pixel.
// Latency: load/advance take effect on the next edge; no backpressure, holds when idle.
module raster_scan_counter
  import gpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  coord_t xmin,
  input  coord_t ymin,
  input  coord_t xmax,
  input  coord_t ymax,
  input  logic   advance,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  coord_t x_lo;
  coord_t x_hi;
  coord_t y_hi;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      x_lo <= '0;
      x_hi <= '0;
      y_hi <= '0;
    end else if (load) begin
      x    <= xmin;
      y    <= ymin;
      x_lo <= xmin;
      x_hi <= xmax;
      y_hi <= ymax;
    end else if (advance) begin
      if (x == x_hi) begin
        x <= x_lo;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Equality end test: never wraps, since the caller stops advancing on last.
  assign last = (x == x_hi) && (y == y_hi);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill into the GPU write port, one pixel per cycle; optional clipping via RECT_CLIP_EN.
// Latency: first write two cycles after accept, done one cycle after the last write.
// Backpressure: cmd_ready low while busy; the write port itself is never stalled.
module rect_fill_engine
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       gpu_clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_x1,
  input  logic [9:0] cmd_y1,
  input  logic [3:0] cmd_color,
  output logic [9:0] gpu_x,
  output logic [9:0] gpu_y,
  output logic [3:0] gpu_data,
  output logic       gpu_we,
  output logic       busy,
  output logic       done
);

`ifdef RECT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);
  localparam coord_t X_END  = coord_t'(SCREEN_W);
  localparam coord_t Y_END  = coord_t'(SCREEN_H);

  fill_state_t state;
  fill_cmd_t   cmd_q;
  coord_t      xmin, xmax, ymin, ymax;
  logic        off_screen;
  logic        scan_last;

  always_comb begin
    xmin       = coord_min(cmd_q.x0, cmd_q.x1);
    xmax       = coord_max(cmd_q.x0, cmd_q.x1);
    ymin       = coord_min(cmd_q.y0, cmd_q.y1);
    ymax       = coord_max(cmd_q.y0, cmd_q.y1);
    off_screen = 1'b0;
    if (CLIP_EN) begin
      if (xmax > X_LAST) xmax = X_LAST;
      if (ymax > Y_LAST) ymax = Y_LAST;
      off_screen = (xmin >= X_END) || (ymin >= Y_END);
    end
  end

  // Counter registers double as gpu_x/gpu_y, so they hold after the last write.
  raster_scan_counter u_scan (
    .clk     (gpu_clk),
    .reset_n (reset_n),
    .load    ((state == SETUP) && !off_screen),
    .xmin    (xmin),
    .ymin    (ymin),
    .xmax    (xmax),
    .ymax    (ymax),
    .advance ((state == FILL) && !scan_last),
    .x       (gpu_x),
    .y       (gpu_y),
    .last    (scan_last)
  );

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge gpu_clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      gpu_data <= '0;
      gpu_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_q <= '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
          busy  <= 1'b1;
          state <= SETUP;
        end
        SETUP: if (off_screen) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          gpu_we   <= 1'b1;
          gpu_data <= cmd_q.color;
          state    <= FILL;
        end
        FILL: if (scan_last) begin
          gpu_we <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: scenario tasks against a loop-based rectangle model.
module tb_rect_fill_engine;
  import gpu_pkg::*;

  logic       gpu_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [3:0] cmd_color = '0;
  logic [9:0] gpu_x, gpu_y;
  logic [3:0] gpu_data;
  logic       gpu_we, busy, done;

  rect_fill_engine dut (
    .gpu_clk(gpu_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .gpu_x(gpu_x), .gpu_y(gpu_y), .gpu_data(gpu_data), .gpu_we(gpu_we),
    .busy(busy), .done(done)
  );

  always #5 gpu_clk = ~gpu_clk;

  typedef struct { int x; int y; int d; int c; } wr_t;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  viol = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  done_q[$];

  always @(posedge gpu_clk) cyc <= cyc + 1;

  // Observed write stream and done pulses, tagged with the cycle they were visible in.
  always @(negedge gpu_clk) begin
    if (gpu_we) begin
      wr_q.push_back('{int'(gpu_x), int'(gpu_y), int'(gpu_data), cyc});
      if (!busy || cmd_ready) viol++;
    end
    if (done) done_q.push_back(cyc);
  end

  // Reference: every pixel of the normalised (and optionally clipped) box, rows outer.
  function automatic void add_model(input int x0, input int y0, input int x1, input int y1, input int d);
    int xa, xb, ya, yb;
    xa = (x0 < x1) ? x0 : x1;
    xb = (x0 < x1) ? x1 : x0;
    ya = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
`ifdef RECT_CLIP_EN
    if (xa >= 320 || ya >= 240) return;
    if (xb > 319) xb = 319;
    if (yb > 239) yb = 239;
`endif
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        exp_q.push_back('{x, y, d, 0});
  endfunction

  function automatic int first_diff();
    int n;
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (wr_q[i].x != exp_q[i].x || wr_q[i].y != exp_q[i].y || wr_q[i].d != exp_q[i].d) return i;
    if (wr_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic void clear_all();
    wr_q.delete();
    exp_q.delete();
    done_q.delete();
    viol = 0;
  endfunction

  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1, input int col,
                         output int acc, output bit to);
    int n;
    @(negedge gpu_clk);
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = 4'(col);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge gpu_clk); n++; end
    acc = cyc + 1;
    @(negedge gpu_clk);
    cmd_valid = 1'b0;
    // Scramble inputs after accept: the engine must work from its latched copy.
    cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom); cmd_x1 = 10'($urandom); cmd_y1 = 10'($urandom);
    cmd_color = 4'($urandom);
    n = 0;
    while (done_q.size() == 0 && n < 80000) begin @(negedge gpu_clk); n++; end
    to = (done_q.size() == 0);
    repeat (3) @(negedge gpu_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge gpu_clk);
    tests++;
    if ({gpu_we, busy, done, gpu_x, gpu_y, gpu_data} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b x=%0d y=%0d d=%0h, want all 0",
               gpu_we, busy, done, gpu_x, gpu_y, gpu_data);
    end
    reset_n = 1'b1;
    @(negedge gpu_clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: cmd_ready=%b, want 1", cmd_ready);
    end
  endtask

  task automatic test_single_pixel();
    int acc, fw, d; bit to;
    clear_all();
    add_model(5, 7, 5, 7, 4'hA);
    run_cmd(5, 7, 5, 7, 4'hA, acc, to);
    d = first_diff();
    tests++;
    if (to || d != -1) begin
      fails++; $display("FAIL single_writes: diff at %0d, got %0d writes, want 1 (timeout=%b)", d, wr_q.size(), to);
    end
    fw = (wr_q.size() > 0) ? wr_q[0].c : -1;
    tests++;
    if (fw != acc + 1) begin
      fails++; $display("FAIL single_latency: first write cycle %0d, want %0d", fw, acc + 1);
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != fw + 1) begin
      fails++; $display("FAIL single_done: %0d pulses, first at %0d, want 1 at %0d",
                        done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, fw + 1);
    end
  endtask

  task automatic test_swapped();
    int acc, d; bit to;
    clear_all();
    add_model(3, 2, 1, 1, 4'h3);
    run_cmd(3, 2, 1, 1, 4'h3, acc, to);
    d = first_diff();
    tests++;
    if (to || d != -1 || wr_q.size() != 6) begin
      fails++; $display("FAIL swapped_writes: diff at %0d, got %0d writes, want 6", d, wr_q.size());
    end
    tests++;
    if (done_q.size() != 1 || wr_q.size() == 0 || done_q[0] != wr_q[wr_q.size()-1].c + 1) begin
      fails++; $display("FAIL swapped_done: %0d done pulses, want 1 right after last write", done_q.size());
    end
  endtask

  task automatic test_random_rects();
    int acc, d, x0, y0, x1, y1, col, n; bit to;
    for (int it = 0; it < 6; it++) begin
      clear_all();
      x0 = $urandom_range(0, 300); y0 = $urandom_range(0, 220);
      x1 = x0 + $urandom_range(0, 12); y1 = y0 + $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) begin n = x0; x0 = x1; x1 = n; end
      if ($urandom_range(0, 1) == 1) begin n = y0; y0 = y1; y1 = n; end
      col = $urandom_range(0, 15);
      add_model(x0, y0, x1, y1, col);
      run_cmd(x0, y0, x1, y1, col, acc, to);
      d = first_diff();
      tests++;
      if (to || d != -1) begin
        fails++; $display("FAIL random_writes[%0d]: (%0d,%0d)-(%0d,%0d) diff at %0d, got %0d writes, want %0d",
                          it, x0, y0, x1, y1, d, wr_q.size(), exp_q.size());
      end
      n = (wr_q.size() > 0) ? wr_q[wr_q.size()-1].c - wr_q[0].c + 1 : -1;
      tests++;
      if (wr_q.size() == 0 || wr_q[0].c != acc + 1 || n != wr_q.size()) begin
        fails++; $display("FAIL random_timing[%0d]: span %0d cycles for %0d writes, first at %0d, want %0d",
                          it, n, wr_q.size(), (wr_q.size() > 0) ? wr_q[0].c : -1, acc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b, na, n;
    clear_all();
    add_model(2, 3, 6, 4, 5);
    na = exp_q.size();
    add_model(8, 8, 7, 9, 12);
    @(negedge gpu_clk);
    cmd_x0 = 10'd2; cmd_y0 = 10'd3; cmd_x1 = 10'd6; cmd_y1 = 10'd4; cmd_color = 4'd5;
    cmd_valid = 1'b1;
    acc_a = cyc + 1;
    @(negedge gpu_clk);
    cmd_x0 = 10'd8; cmd_y0 = 10'd8; cmd_x1 = 10'd7; cmd_y1 = 10'd9; cmd_color = 4'd12;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge gpu_clk); n++; end
    acc_b = cyc + 1;
    @(negedge gpu_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (done_q.size() < 2 && n < 200) begin @(negedge gpu_clk); n++; end
    repeat (3) @(negedge gpu_clk);
    tests++;
    if (first_diff() != -1) begin
      fails++; $display("FAIL b2b_writes: diff at %0d, got %0d writes, want %0d", first_diff(), wr_q.size(), exp_q.size());
    end
    tests++;
    if (done_q.size() != 2 || done_q[0] + 2 != acc_b) begin
      fails++; $display("FAIL b2b_accept: second accept at %0d, want %0d (%0d done pulses, first cmd at %0d)",
                        acc_b, (done_q.size() > 0) ? done_q[0] + 2 : -1, done_q.size(), acc_a);
    end
    tests++;
    if (wr_q.size() <= na || wr_q[na].c != acc_b + 1 || wr_q[na-1].c >= done_q[0]) begin
      fails++; $display("FAIL b2b_overlap: second fill first write at %0d, want %0d",
                        (wr_q.size() > na) ? wr_q[na].c : -1, acc_b + 1);
    end
  endtask

  task automatic test_full_clear();
    int acc, d; bit to;
    clear_all();
    add_model(0, 0, 319, 239, 0);
    run_cmd(0, 0, 319, 239, 0, acc, to);
    d = first_diff();
    tests++;
    if (to || d != -1 || wr_q.size() != 76800) begin
      fails++; $display("FAIL clear_writes: diff at %0d, got %0d writes, want 76800", d, wr_q.size());
    end
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL clear_busy: %0d write cycles with busy low or cmd_ready high, want 0", viol);
    end
    tests++;
    if (done_q.size() != 1 || wr_q.size() == 0 || done_q[0] != wr_q[wr_q.size()-1].c + 1) begin
      fails++; $display("FAIL clear_done: %0d done pulses, want 1 right after last write", done_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int n, seen;
    clear_all();
    @(negedge gpu_clk);
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd9; cmd_y1 = 10'd9; cmd_color = 4'h9;
    cmd_valid = 1'b1;
    @(negedge gpu_clk);
    cmd_valid = 1'b0;
    seen = 0; n = 0;
    while (seen < 20 && n < 100) begin
      @(negedge gpu_clk); n++;
      if (gpu_we) seen++;
    end
    reset_n = 1'b0;
    @(negedge gpu_clk);
    tests++;
    if ({gpu_we, busy, done, gpu_x, gpu_y, gpu_data} !== 27'd0) begin
      fails++; $display("FAIL midreset_outputs: we=%b busy=%b x=%0d y=%0d d=%0h, want all 0",
                        gpu_we, busy, gpu_x, gpu_y, gpu_data);
    end
    @(negedge gpu_clk);
    reset_n = 1'b1;
    @(negedge gpu_clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL midreset_ready: cmd_ready=%b, want 1", cmd_ready);
    end
    repeat (5) @(negedge gpu_clk);
    tests++;
    if (wr_q.size() != 20 || done_q.size() != 0) begin
      fails++; $display("FAIL midreset_abort: %0d writes and %0d done pulses, want 20 and 0", wr_q.size(), done_q.size());
    end
  endtask

`ifdef RECT_CLIP_EN
  task automatic test_clip();
    int acc, d; bit to;
    clear_all();
    add_model(310, 230, 400, 300, 7);
    run_cmd(310, 230, 400, 300, 7, acc, to);
    d = first_diff();
    tests++;
    if (to || d != -1 || wr_q.size() != 100) begin
      fails++; $display("FAIL clip_partial: diff at %0d, got %0d writes, want 100", d, wr_q.size());
    end
    clear_all();
    run_cmd(330, 0, 340, 5, 2, acc, to);
    tests++;
    if (to || wr_q.size() != 0 || done_q.size() != 1) begin
      fails++; $display("FAIL clip_offscreen: %0d writes, %0d done pulses, want 0 and 1", wr_q.size(), done_q.size());
    end
  endtask
`else
  task automatic test_clip();
    int acc, d; bit to;
    clear_all();
    add_model(315, 3, 325, 3, 6);
    run_cmd(315, 3, 325, 3, 6, acc, to);
    d = first_diff();
    tests++;
    if (to || d != -1 || wr_q.size() != 11) begin
      fails++; $display("FAIL noclip_verbatim: diff at %0d, got %0d writes, want 11", d, wr_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pixel();
    test_swapped();
    test_random_rects();
    test_back_to_back();
    test_full_clear();
    test_reset_mid_fill();
    test_clip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
